vedic_div_16by8: RTL and testbench

Sequential restoring divider that inverts the 8-bit Vedic multiplier: it takes a 16-bit dividend, such as a multiplier product, and an 8-bit divisor. It returns a 16-bit quotient and an 8-bit remainder, one quotient bit per clock. It sits beside the multiplier as the round-trip checker and general divide unit, with valid/ready handshakes on both sides.

---
 rtl/vedic_div_16by8.sv | 133 +++++++++++++
 tb/tb_vedic_div_16by8.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_div_16by8.sv
// vedic_div_16by8: sequential restoring divider, 16-bit dividend by 8-bit divisor.
// Produces one quotient bit per clock (16 CALC cycles) with valid/ready on both sides.
// Optional macro DIV_FAST_ZERO_EN: divisor 0 or dividend < divisor skips the CALC
// iterations and reaches DONE one cycle after acceptance (results unchanged).
module vedic_div_16by8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2,
        S_FAST = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dvd_q, dvd_d;   // dividend shifting out MSB-first, quotient bits shifting in
    logic [7:0]  dsr_q, dsr_d;   // latched divisor
    logic [7:0]  rem_q, rem_d;   // partial remainder; bit 8 is always 0 after an update
    logic [4:0]  cnt_q, cnt_d;   // iteration counter
    logic [15:0] quo_q, quo_d;   // published quotient, held until the next result
    logic [7:0]  rmd_q, rmd_d;   // published remainder, held until the next result

    logic [8:0]  shifted;
    logic        take_sub;
    logic [7:0]  rem_nxt;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        shifted  = {rem_q, dvd_q[15]};
        take_sub = (shifted >= {1'b0, dsr_q});
        // When the subtraction is taken the true result is below the divisor,
        // so the low 8 bits of the difference are exact.
        rem_nxt  = take_sub ? (shifted[7:0] - dsr_q) : shifted[7:0];
    end

    // Next-state and datapath update; every target defaults to hold.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    rem_d = 8'd0;
                    cnt_d = 5'd0;
`ifdef DIV_FAST_ZERO_EN
                    if ((divisor == 8'd0) || (dividend < {8'd0, divisor})) begin
                        state_d = S_FAST;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                dvd_d = {dvd_q[14:0], take_sub};
                rem_d = rem_nxt;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    quo_d   = {dvd_q[14:0], take_sub};
                    rmd_d   = rem_nxt;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifdef DIV_FAST_ZERO_EN
            S_FAST: begin
                // Divisor 0 saturates the quotient; a small dividend is its own remainder.
                quo_d   = (dsr_q == 8'd0) ? 16'hFFFF : 16'h0000;
                rmd_d   = dvd_q[7:0];
                state_d = S_DONE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= 16'd0;
            dsr_q   <= 8'd0;
            rem_q   <= 8'd0;
            cnt_q   <= 5'd0;
            quo_q   <= 16'd0;
            rmd_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
        end
    end

    // Handshake and status outputs decode the state alone.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_CALC);
        out_valid = (state_q == S_DONE);
        quotient  = quo_q;
        remainder = rmd_q;
    end

endmodule

// File: tb/tb_vedic_div_16by8.sv
// Testbench for vedic_div_16by8: latency-level reference model checked every cycle,
// directed literal cases, backpressure, mid-operation reset, back-to-back and random traffic.
module tb_vedic_div_16by8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dividend = 16'd0;
    logic [7:0]  divisor = 8'd0;
    logic        in_ready, out_valid, busy;
    logic [15:0] quotient;
    logic [7:0]  remainder;

`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int LAT_FULL = 16;  // edges after the accept edge until out_valid

    vedic_div_16by8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? a[7:0] : 8'(a % {8'd0, b});
    endfunction

    function automatic int ref_lat(input logic [15:0] a, input logic [7:0] b);
        if (FAST && ((b == 8'd0) || (a < {8'd0, b}))) return 1;
        return LAT_FULL;
    endfunction

    // Reference model: tracks idle / working / result-held and expected outputs.
    typedef enum {M_IDLE, M_WORK, M_DONE} mph_t;
    mph_t        ph = M_IDLE;
    int          m_wait = 0;
    bit          m_fast = 1'b0;
    logic [15:0] m_q = 16'd0, p_q = 16'd0;
    logic [7:0]  m_r = 8'd0,  p_r = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph = M_IDLE; m_wait = 0; m_fast = 1'b0; m_q = 16'd0; m_r = 8'd0;
        end
        check("in_ready",  32'(in_ready),  32'(ph == M_IDLE));
        check("busy",      32'(busy),      32'((ph == M_WORK) && !m_fast));
        check("out_valid", 32'(out_valid), 32'(ph == M_DONE));
        check("quotient",  32'(quotient),  32'(m_q));
        check("remainder", 32'(remainder), 32'(m_r));
        if (rst_n) begin
            case (ph)
                M_IDLE: if (in_valid) begin
                    p_q    = ref_q(dividend, divisor);
                    p_r    = ref_r(dividend, divisor);
                    m_wait = ref_lat(dividend, divisor);
                    m_fast = (m_wait == 1);
                    ph     = M_WORK;
                end
                M_WORK: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        ph = M_DONE; m_q = p_q; m_r = p_r; m_fast = 1'b0;
                    end
                end
                M_DONE: if (out_ready) ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!in_ready && k < 60) begin tick(); k++; end
        check("ready_before_op", 32'(in_ready), 32'd1);
    endtask

    // Issue one operation, check latency and literal result, then drain it.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input int lat);
        int k = 0;
        wait_idle();
        out_ready = 1'b1;
        dividend = a; divisor = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && k < 40) begin tick(); k++; end
        check("op_latency", 32'(k), 32'(lat));
        check("op_quotient", 32'(quotient), 32'(eq));
        check("op_remainder", 32'(remainder), 32'(er));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int sel;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Multiplier round-trips and boundary operands
        do_op(16'd40,   8'd8,   16'd5,    8'd0, LAT_FULL);
        do_op(16'd225,  8'd15,  16'd15,   8'd0, LAT_FULL);
        do_op(16'd675,  8'd27,  16'd25,   8'd0, LAT_FULL);
        do_op(16'd380,  8'd20,  16'd19,   8'd0, LAT_FULL);
        do_op(16'hFFFF, 8'h01,  16'hFFFF, 8'd0, LAT_FULL);
        do_op(16'd1000, 8'd7,   16'd142,  8'd6, LAT_FULL);
        do_op(16'h1234, 8'd0,   16'hFFFF, 8'h34, FAST ? 1 : LAT_FULL);
        do_op(16'd5,    8'd200, 16'd0,    8'd5, FAST ? 1 : LAT_FULL);

        // Backpressure: result must hold while new operands are offered
        wait_idle();
        out_ready = 1'b0;
        dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin tick(); k++; end
        check("bp_latency", 32'(k), 32'(LAT_FULL));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 16'($urandom); divisor = 8'($urandom_range(1, 255));
            tick();
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_quotient_held", 32'(quotient), 32'd142);
            check("bp_remainder_held", 32'(remainder), 32'd6);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_hold_after", 32'(quotient), 32'd142);
        out_ready = 1'b0;

        // Reset in the eighth busy cycle
        dividend = 16'd5000; divisor = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        do_op(16'd100, 8'd9, 16'd11, 8'd1, LAT_FULL);

        // Back-to-back with in_valid and out_ready held high
        wait_idle();
        out_ready = 1'b1;
        dividend = 16'd255; divisor = 8'd16; in_valid = 1'b1;
        tick();
        dividend = 16'd300; divisor = 8'd255;
        k = 0;
        while (!out_valid && k < 40) begin tick(); k++; end
        check("b2b1_latency", 32'(k), 32'(LAT_FULL));
        check("b2b1_quotient", 32'(quotient), 32'd15);
        check("b2b1_remainder", 32'(remainder), 32'd15);
        tick();
        check("b2b_idle_between", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin tick(); k++; end
        check("b2b2_latency", 32'(k), 32'(LAT_FULL));
        check("b2b2_quotient", 32'(quotient), 32'd1);
        check("b2b2_remainder", 32'(remainder), 32'd45);
        tick();

        // Random traffic with random backpressure and ignored operands while busy
        for (int n = 0; n < 40; n++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; tick(); end
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                divisor = 8'd0; dividend = 16'($urandom);
            end else if (sel == 1) begin
                divisor = 8'($urandom_range(1, 255));
                dividend = 16'($urandom_range(0, int'(divisor) - 1));
            end else begin
                divisor = 8'($urandom_range(1, 255)); dividend = 16'($urandom);
            end
            in_valid = 1'b1;
            tick();
            k = 0;
            do begin
                in_valid  = 1'($urandom_range(0, 1));
                dividend  = 16'($urandom);
                divisor   = 8'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                tick();
                k++;
            end while (!in_ready && k < 100);
            check("rand_complete", 32'(in_ready), 32'd1);
            in_valid = 1'b0; out_ready = 1'b0;
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
